// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential multiply/divide unit: FSM state and opcode
// encodings, plus the default operand width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement negate; yields operand magnitudes and applies
// the final sign of the quotient and remainder.
module muldiv_abs_neg
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring on magnitudes).
// Define MULDIV_OVF_FLAG_EN to add the registered ovf output.
//
// state | meaning
// IDLE  | waiting for start; done pulses here after a completion
// RUN   | one Booth / non-restoring iteration per cycle, WIDTH cycles
// FIX   | divide remainder and sign correction, result registers written
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhigh,
  output logic [WIDTH-1:0] zlow,
  output logic             div_by_zero
`ifdef MULDIV_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc is one bit wider than the operands so Booth on -2^(W-1) and the
  // non-restoring partial remainder never overflow.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic             op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] zhigh_q, zhigh_d;
  logic [WIDTH-1:0] zlow_q, zlow_d;
  logic             dbz_out_q, dbz_out_d;
`ifdef MULDIV_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_raw, rem_fix;
  logic [WIDTH:0]   booth_sum, div_shift, div_sum;

  muldiv_abs_neg #(.WIDTH(WIDTH)) u_a_mag (.val_i(a_in), .neg_i(a_in[WIDTH-1]), .val_o(a_mag));
  muldiv_abs_neg #(.WIDTH(WIDTH)) u_b_mag (.val_i(b_in), .neg_i(b_in[WIDTH-1]), .val_o(b_mag));
  muldiv_abs_neg #(.WIDTH(WIDTH)) u_quo (.val_i(q_q), .neg_i(a_neg_q ^ b_neg_q), .val_o(quo_fix));
  muldiv_abs_neg #(.WIDTH(WIDTH)) u_rem (.val_i(rem_raw), .neg_i(a_neg_q), .val_o(rem_fix));

  always_comb begin
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign div_sum   = acc_q[WIDTH] ? (div_shift + m_q) : (div_shift - m_q);
  assign rem_raw   = acc_q[WIDTH] ? (acc_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    op_d      = op_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    zhigh_d   = zhigh_q;
    zlow_d    = zlow_q;
    dbz_out_d = dbz_out_q;
`ifdef MULDIV_OVF_FLAG_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          if (op == OP_DIV) begin
            m_d     = {1'b0, b_mag};
            q_d     = a_mag;
            a_neg_d = a_in[WIDTH-1];
            b_neg_d = b_in[WIDTH-1];
            dbz_d   = (b_in == '0);
            // Divide by zero skips iteration; the raw dividend is kept for zhigh.
            if (b_in == '0) begin
              q_d     = a_in;
              state_d = FIX;
            end else begin
              state_d = RUN;
            end
          end else begin
            m_d     = {a_in[WIDTH-1], a_in};
            q_d     = b_in;
            a_neg_d = 1'b0;
            b_neg_d = 1'b0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (op_q == OP_MUL) begin
          acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
        end else begin
          acc_d = div_sum;
          q_d   = {q_q[WIDTH-2:0], ~div_sum[WIDTH]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (op_q == OP_MUL) begin
          zhigh_d   = acc_q[WIDTH-1:0];
          zlow_d    = q_q;
          dbz_out_d = 1'b0;
`ifdef MULDIV_OVF_FLAG_EN
          ovf_d     = (acc_q[WIDTH-1:0] != {WIDTH{q_q[WIDTH-1]}});
`endif
        end else if (dbz_q) begin
          zhigh_d   = q_q;
          zlow_d    = '1;
          dbz_out_d = 1'b1;
`ifdef MULDIV_OVF_FLAG_EN
          ovf_d     = 1'b0;
`endif
        end else begin
          zhigh_d   = rem_fix;
          zlow_d    = quo_fix;
          dbz_out_d = 1'b0;
`ifdef MULDIV_OVF_FLAG_EN
          // Only -2^(W-1) / -1 yields an unnegated quotient magnitude of 2^(W-1).
          ovf_d     = q_q[WIDTH-1] & ~(a_neg_q ^ b_neg_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      op_q      <= 1'b0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      zhigh_q   <= '0;
      zlow_q    <= '0;
      dbz_out_q <= 1'b0;
`ifdef MULDIV_OVF_FLAG_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      op_q      <= op_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      zhigh_q   <= zhigh_d;
      zlow_q    <= zlow_d;
      dbz_out_q <= dbz_out_d;
`ifdef MULDIV_OVF_FLAG_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign zhigh       = zhigh_q;
  assign zlow        = zlow_q;
  assign div_by_zero = dbz_out_q;
`ifdef MULDIV_OVF_FLAG_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results are queued at start and
// compared when done pulses; latency, busy span, hold and reset abort are checked.
module tb_mul_div_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, div_by_zero;
  logic [W-1:0] zhigh, zlow;
`ifdef MULDIV_OVF_FLAG_EN
  logic         ovf;
`endif

  mul_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .zhigh(zhigh), .zlow(zlow), .div_by_zero(div_by_zero)
`ifdef MULDIV_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic         ovf;
  } exp_t;

  exp_t         sb_q[$];
  int           n_chk = 0;
  int           n_bad = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (o == OP_MUL) begin
      p     = sa * sb;
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.ovf = (e.hi != {W{e.lo[W-1]}});
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      q     = sa / sb;
      r     = sa % sb;
      e.lo  = q[31:0];
      e.hi  = r[31:0];
      e.ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("zhigh", zhigh, e.hi);
        chk("zlow", zlow, e.lo);
        chk("div_by_zero", div_by_zero, e.dbz);
`ifdef MULDIV_OVF_FLAG_EN
        chk("ovf", ovf, e.ovf);
`endif
      end
    end
  end

  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    int   lat, done_cyc, nbusy, ndone;
    exp_t e;
    lat = (o == OP_DIV && b == '0) ? 2 : W + 2;
    e   = model(o, a, b);
    @(negedge clock);
    start = 1'b1; op = o; a_in = a; b_in = b;
    sb_q.push_back(e);
    done_cyc = -1; nbusy = 0; ndone = 0;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0; op = ~o; a_in = $urandom; b_in = $urandom;
      end
      if (k == lat - 1) begin
        chk("hold_hi", zhigh, prev_hi);
        chk("hold_lo", zlow, prev_lo);
      end
      if (busy) nbusy++;
      if (done) begin ndone++; done_cyc = k; end
    end
    chk("latency", done_cyc, lat);
    chk("busy_cycles", nbusy, lat - 1);
    chk("done_count", ndone, 1);
    prev_hi = e.hi;
    prev_lo = e.lo;
  endtask

  initial begin
    int           d1, d2, nd;
    logic         ro;
    logic [W-1:0] ra, rb;
    exp_t         e2;

    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_zhigh", zhigh, '0);
    chk("rst_zlow", zlow, '0);
    chk("rst_dbz", div_by_zero, 1'b0);
    reset = 1'b0;

    run_op(OP_MUL, 32'd7, -32'sd3);
    run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000);
    run_op(OP_MUL, 32'h7FFF_FFFF, 32'd2);
    run_op(OP_DIV, -32'sd7, 32'd2);
    run_op(OP_DIV, 32'd100, -32'sd7);
    run_op(OP_DIV, 32'd100, 32'd0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'd1);
    for (int i = 0; i < 6; i++) begin
      ro = $urandom_range(0, 1);
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom_range(0, 1) ? $urandom : $urandom_range(1, 300);
      run_op(ro, ra, rb);
    end

    // start held high: second operation is accepted in the first one's done cycle
    @(negedge clock);
    start = 1'b1; op = OP_MUL; a_in = 32'd3; b_in = 32'd5;
    sb_q.push_back(model(OP_MUL, 32'd3, 32'd5));
    e2 = model(OP_MUL, 32'd6, -32'sd7);
    sb_q.push_back(e2);
    d1 = -1; d2 = -1; nd = 0;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clock);
      if (k == 1) begin a_in = 32'd6; b_in = -32'sd7; end
      if (k == 35) begin
        chk("b2b_busy", busy, 1'b1);
        start = 1'b0;
      end
      if (done) begin
        nd++;
        if (nd == 1) d1 = k; else d2 = k;
      end
    end
    chk("b2b_first", d1, 34);
    chk("b2b_second", d2, 68);
    chk("b2b_count", nd, 2);
    prev_hi = e2.hi;
    prev_lo = e2.lo;

    // reset mid-operation aborts without a done pulse and clears the result
    @(negedge clock);
    start = 1'b1; op = OP_MUL; a_in = 32'd9; b_in = 32'd9;
    nd = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 10) reset = 1'b1;
      if (k == 11) begin
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_zhigh", zhigh, '0);
        chk("abort_zlow", zlow, '0);
        chk("abort_dbz", div_by_zero, 1'b0);
      end
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    prev_hi = '0;
    prev_lo = '0;

    run_op(OP_MUL, 32'd5, 32'd5);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Sequential signed multiply/divide unit for the CPU datapath.
- Registered 64-bit result drives the Zhigh/Zlow inputs of the bus multiplexer, either directly or through the Z register.
- Started by the control unit for mul/div instructions. Multiply uses radix-2 Booth; divide uses non-restoring division on magnitudes.
- Multi-cycle; start/busy/done handshake.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH split into zhigh/zlow.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = multiply, 1 = divide
a_in  input  WIDTH  multiplicand / dividend (signed)
b_in  input  WIDTH  multiplier / divisor (signed)
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
zhigh  output  WIDTH  mul: product[2W-1:W]; div: remainder
zlow  output  WIDTH  mul: product[W-1:0]; div: quotient
div_by_zero  output  1  registered with done; high if the last divide had b_in == 0

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE; busy, done, div_by_zero = 0; zhigh, zlow = 0; internal counter, accumulator and operand registers = 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1: latch op, a_in, b_in; counter=0; next state RUN.
  - Exception: op=1 and b_in==0 goes straight to FIX.
  - start=0: stay in IDLE.
- RUN:
  - One iteration per cycle.
  - After WIDTH iterations (counter == WIDTH-1), go to FIX.
- FIX:
  - Divide: remainder correction (add divisor back if partial remainder is negative), then sign correction.
  - Write zhigh/zlow; return to IDLE.
- Timing (start sampled at cycle 0):
  - busy = 1 in cycles 1..WIDTH+1.
  - done = 1 in cycle WIDTH+2 only (34 for WIDTH=32).
  - Div-by-zero: busy in cycle 1, done in cycle 2.
- done is registered and asserts in IDLE. start in the done cycle is accepted (back-to-back).
- start while busy is ignored; no queuing.
- a_in/b_in/op changes after the start cycle have no effect.
- zhigh/zlow/div_by_zero hold their value until the next completion; they never change mid-operation.
- Multiply:
  - Booth on a WIDTH+1-bit signed accumulator so that a_in = -2^(W-1) is exact.
  - Full 2W-bit signed product; never overflows.
- Divide:
  - Operate on unsigned magnitudes.
  - Quotient truncates toward zero.
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^(W-1) / -1 gives quotient 0x80000000 (wrap) and remainder 0.
- Divide by zero: zlow = all ones, zhigh = dividend, div_by_zero = 1.
- Reset mid-operation: abort immediately. Next cycle is IDLE with busy=0; done never pulses for the aborted operation; outputs return to 0.

Optional Feature:
- Macro: MULDIV_OVF_FLAG_EN.
- Defined:
  - Adds output ovf (1 bit), registered with done and held like zhigh/zlow.
  - Multiply: ovf=1 when the product does not fit in WIDTH signed bits (zhigh is not the sign extension of zlow[W-1]).
  - Divide: ovf=1 for -2^(W-1) / -1.
  - Divide by zero: ovf=0.
  - Reset value 0.
- Undefined: port absent; all other behaviour identical.

Decomposition:
- Shared package muldiv_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, FIX=2'd2
  - op encoding: OP_MUL=1'b0, OP_DIV=1'b1
  - default WIDTH constant
- One sub-module, muldiv_abs_neg:
  - Combinational conditional two's-complement negate.
  - Used for operand magnitudes and for result sign fix.
- FSM, counter and datapath stay in the top module.

Test Plan:
- Signed multiply: op=0, a=7, b=-3 -> done at cycle 34; zhigh=FFFFFFFF, zlow=FFFFFFEB; busy high cycles 1..33.
- Multiply corner: a=b=0x80000000 -> zhigh=40000000, zlow=00000000 (ovf=1 with macro). Also 0x7FFFFFFF*2 -> zhigh=0, zlow=FFFFFFFE.
- Signed divide: a=-7, b=2 -> zlow=FFFFFFFD, zhigh=FFFFFFFF. Also a=100, b=-7 -> zlow=FFFFFFF2, zhigh=00000002.
- Divide edge cases:
  - a=100, b=0 -> done at cycle 2; div_by_zero=1; zlow=FFFFFFFF; zhigh=00000064.
  - a=0x80000000, b=-1 -> zlow=80000000, zhigh=0.
- Handshake and reset:
  - start held high through a multiply -> exactly one done, then a second operation accepted in the done cycle, with its done 34 cycles later.
  - reset at cycle 10 -> busy=0 at cycle 11; no done; zhigh=zlow=0.
